// File: rtl/tmem_ctrl.sv
// Tagged main-memory controller: latched word address, RD_LAT-cycle reads, atomic RMW lock.
// Optional macro TMEM_PARITY_EN adds a stored parity bit per word and flags mismatches on read.
module tmem_ctrl #(
    parameter int AW     = 20,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   i_ad,
    input  logic [7:0]    i_tag,
    input  logic          i_astb,
    input  logic          i_atomic,
    input  logic          i_rd,
    input  logic          i_wr,
    output logic [63:0]   o_data,
    output logic [7:0]    o_tag,
    output logic          o_rvalid,
    output logic          o_busy,
    output logic          o_err,
    output logic [AW-1:0] o_waddr
);

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("tmem_ctrl: RD_LAT must be in 1..4");
        end
    endgenerate

`ifdef TMEM_PARITY_EN
    localparam int MW = 73;
`else
    localparam int MW = 72;
`endif
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        RD_WAIT = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t        state_q;
    logic          lock_q;
    logic [2:0]    cnt_q;
    logic          rvalid_q;
    logic          busy_q;
    logic          err_q;
    logic          dvalid_q;
    logic [AW-1:0] waddr_q;

    logic [MW-1:0] mem_q [0:(1<<AW)-1];
    logic [MW-1:0] rd_word_q;
    logic [MW-1:0] wr_word;

    logic bad_combo;
    logic proto_err;
    logic acc_astb;
    logic acc_rd;
    logic acc_wr;

    // Illegal strobe combinations are rejected regardless of state.
    assign bad_combo = (i_rd & i_wr) | (i_astb & (i_rd | i_wr));

    always_comb begin
        proto_err = 1'b0;
        acc_astb  = 1'b0;
        acc_rd    = 1'b0;
        acc_wr    = 1'b0;
        if (bad_combo) begin
            proto_err = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_astb  = i_astb;
                    proto_err = i_rd | i_wr;
                end
                ADDR: begin
                    acc_astb = i_astb;
                    acc_rd   = i_rd;
                    acc_wr   = i_wr;
                end
                RD_WAIT: begin
                    proto_err = i_astb | i_rd | i_wr;
                end
                LOCKED: begin
                    acc_wr    = i_wr;
                    proto_err = i_astb | i_rd;
                end
                default: begin
                    proto_err = 1'b0;
                end
            endcase
        end
    end

`ifdef TMEM_PARITY_EN
    assign wr_word = {^{i_tag, i_ad}, i_tag, i_ad};
`else
    assign wr_word = {i_tag, i_ad};
`endif

    // Array kept free of reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem_q[waddr_q] <= wr_word;
        end
        if (acc_rd) begin
            rd_word_q <= mem_q[waddr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lock_q   <= 1'b0;
            cnt_q    <= 3'd0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            dvalid_q <= 1'b0;
            waddr_q  <= '0;
        end else begin
            err_q    <= proto_err;
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acc_astb) begin
                        waddr_q <= i_ad[AW-1:0];
                        lock_q  <= i_atomic;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (acc_astb) begin
                        waddr_q <= i_ad[AW-1:0];
                        lock_q  <= i_atomic;
                    end else if (acc_rd) begin
                        state_q  <= RD_WAIT;
                        busy_q   <= 1'b1;
                        dvalid_q <= 1'b1;
                        cnt_q    <= LAT_M1;
                        rvalid_q <= (RD_LAT == 1);
                    end else if (acc_wr) begin
                        lock_q <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    // The strobe cycle is the last one spent waiting.
                    if (rvalid_q) begin
                        state_q <= lock_q ? LOCKED : ADDR;
                        busy_q  <= 1'b0;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q    <= cnt_q - 3'd1;
                        rvalid_q <= (cnt_q == 3'd1);
                    end
                end
                LOCKED: begin
                    if (acc_wr) begin
                        lock_q  <= 1'b0;
                        state_q <= ADDR;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_rvalid = rvalid_q;
    assign o_busy   = busy_q;
    assign o_waddr  = waddr_q;
    assign o_data   = dvalid_q ? rd_word_q[63:0]  : 64'd0;
    assign o_tag    = dvalid_q ? rd_word_q[71:64] : 8'd0;

`ifdef TMEM_PARITY_EN
    logic par_bad;
    assign par_bad = rvalid_q & ((^rd_word_q[71:0]) != rd_word_q[72]);
    assign o_err   = err_q | par_bad;
`else
    assign o_err   = err_q;
`endif

endmodule

// File: tb/tb_tmem_ctrl.sv
// Scoreboard bench for tmem_ctrl (RD_LAT=3): stimulus queues expected reads/errors with their
// due cycle, a monitor process pops and compares whenever o_rvalid or o_err is seen.
module tb_tmem_ctrl;
    localparam int AW     = 20;
    localparam int RD_LAT = 3;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic [63:0]   i_ad     = '0;
    logic [7:0]    i_tag    = '0;
    logic          i_astb   = 1'b0;
    logic          i_atomic = 1'b0;
    logic          i_rd     = 1'b0;
    logic          i_wr     = 1'b0;
    logic [63:0]   o_data;
    logic [7:0]    o_tag;
    logic          o_rvalid;
    logic          o_busy;
    logic          o_err;
    logic [AW-1:0] o_waddr;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic [7:0]  tag;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      err_q[$];

    tmem_ctrl #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_ad     (i_ad),
        .i_tag    (i_tag),
        .i_astb   (i_astb),
        .i_atomic (i_atomic),
        .i_rd     (i_rd),
        .i_wr     (i_wr),
        .o_data   (o_data),
        .o_tag    (o_tag),
        .o_rvalid (o_rvalid),
        .o_busy   (o_busy),
        .o_err    (o_err),
        .o_waddr  (o_waddr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drv(input logic astb, input logic rd, input logic wr, input logic atomic,
                       input logic [63:0] ad, input logic [7:0] tag);
        @(negedge clk);
        i_astb   = astb;
        i_rd     = rd;
        i_wr     = wr;
        i_atomic = atomic;
        i_ad     = ad;
        i_tag    = tag;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
    endtask

    task automatic do_astb(input logic [63:0] ad, input logic atomic);
        drv(1'b1, 1'b0, 1'b0, atomic, ad, 8'd0);
        $display("[%0d] ASTB ad=0x%0h atomic=%0b", cyc, ad, atomic);
    endtask

    task automatic do_wr(input logic [63:0] d, input logic [7:0] t);
        drv(1'b0, 1'b0, 1'b1, 1'b0, d, t);
        $display("[%0d] WR   data=0x%0h tag=0x%0h", cyc, d, t);
    endtask

    task automatic do_rd(input logic [63:0] d, input logic [7:0] t);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 8'd0);
        rd_q.push_back('{due: cyc + RD_LAT, data: d, tag: t});
        $display("[%0d] RD   expect data=0x%0h tag=0x%0h at %0d", cyc, d, t, cyc + RD_LAT);
    endtask

    task automatic do_bad(input logic astb, input logic rd, input logic wr, input logic [63:0] ad);
        drv(astb, rd, wr, 1'b0, ad, 8'hEE);
        err_q.push_back(cyc + 1);
        $display("[%0d] BAD  astb=%0b rd=%0b wr=%0b expect o_err at %0d", cyc, astb, rd, wr, cyc + 1);
    endtask

    initial begin
        rd_exp_t e;
        int      edue;

        fork
            forever begin
                @(negedge clk);
                if (o_rvalid) begin
                    if (rd_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL rvalid_unexpected: got strobe at cycle %0d, expected none", cyc);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                        chk("rd_data", o_data, e.data);
                        chk("rd_tag", 64'(o_tag), 64'(e.tag));
                    end
                end
                if (o_err) begin
                    if (err_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL err_unexpected: got o_err at cycle %0d, expected none", cyc);
                    end else begin
                        edue = err_q.pop_front();
                        chk("err_cycle", 64'(cyc), 64'(edue));
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_tag", 64'(o_tag), 64'd0);
        chk("rst_waddr", 64'(o_waddr), 64'd0);
        reset = 1'b1;

        // Basic write then read
        do_astb(64'h12345, 1'b0);
        do_wr(64'hDEADBEEF_01234567, 8'h35);
        do_rd(64'hDEADBEEF_01234567, 8'h35);
        idle(RD_LAT);
        chk("waddr_basic", 64'(o_waddr), 64'h12345);

        // Latency and busy window; a second rd while waiting is rejected
        do_rd(64'hDEADBEEF_01234567, 8'h35);
        do_bad(1'b0, 1'b1, 1'b0, 64'd0);
        chk("busy_n1", 64'(o_busy), 64'd1);
        idle(1);
        chk("busy_n2", 64'(o_busy), 64'd1);
        idle(1);
        chk("busy_n3", 64'(o_busy), 64'd1);
        idle(1);
        chk("busy_n4", 64'(o_busy), 64'd0);

        // Address wrap: upper i_ad bits ignored
        do_astb(64'hABCD_0000_00F1_2345, 1'b0);
        do_rd(64'hDEADBEEF_01234567, 8'h35);
        chk("waddr_wrap", 64'(o_waddr), 64'h12345);
        idle(RD_LAT);

        // Atomic lock
        do_astb(64'd7, 1'b0);
        do_wr(64'hAAAA, 8'h0A);
        do_astb(64'd7, 1'b1);
        do_rd(64'hAAAA, 8'h0A);
        idle(RD_LAT);
        do_bad(1'b1, 1'b0, 1'b0, 64'd9);
        idle(1);
        chk("waddr_locked", 64'(o_waddr), 64'd7);
        do_bad(1'b0, 1'b1, 1'b0, 64'd0);
        do_wr(64'h5, 8'h06);
        do_rd(64'h5, 8'h06);
        idle(RD_LAT);

        // rd&wr together in ADDR: no write, state kept
        do_bad(1'b0, 1'b1, 1'b1, 64'h999);
        do_rd(64'h5, 8'h06);
        idle(RD_LAT);

        // astb with wr: no write, address kept
        do_bad(1'b1, 1'b0, 1'b1, 64'h42);
        do_rd(64'h5, 8'h06);
        chk("waddr_badastb", 64'(o_waddr), 64'd7);
        idle(RD_LAT);

        // Read-after-write in consecutive cycles
        do_astb(64'h100, 1'b0);
        do_wr(64'h0123_4567_89AB_CDEF, 8'hC3);
        do_rd(64'h0123_4567_89AB_CDEF, 8'hC3);
        idle(RD_LAT);
        do_wr(64'h55, 8'h5A);
        do_rd(64'h55, 8'h5A);
        idle(RD_LAT);

        // Reset during RD_WAIT aborts the read
        do_astb(64'd7, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 8'd0);
        $display("[%0d] RD   aborted by reset", cyc);
        idle(1);
        reset = 1'b0;
        idle(2);
        chk("rstw_busy", 64'(o_busy), 64'd0);
        chk("rstw_waddr", 64'(o_waddr), 64'd0);
        chk("rstw_data", o_data, 64'd0);
        chk("rstw_tag", 64'(o_tag), 64'd0);
        chk("rstw_rvalid", 64'(o_rvalid), 64'd0);
        reset = 1'b1;
        do_bad(1'b0, 1'b1, 1'b0, 64'd0);
        do_bad(1'b0, 1'b0, 1'b1, 64'd0);
        do_astb(64'd7, 1'b0);
        do_rd(64'h5, 8'h06);
        idle(RD_LAT);

`ifdef TMEM_PARITY_EN
        // Corrupted stored bit: data still returned, o_err with o_rvalid
        @(negedge clk);
        dut.mem_q[7] = dut.mem_q[7] ^ 73'd1;
        do_rd(64'h4, 8'h06);
        err_q.push_back(cyc + RD_LAT);
        idle(RD_LAT);
`endif

        idle(6);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        chk("err_q_drained", 64'(err_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
